scarv_soc_bram_bridge: RTL
==========================

Name: scarv_soc_bram_bridge

Overview:
- Initiator that connects a CPU/interconnect memory request/response bus to one port of the dual-port BRAM.
- Decodes an address window, drives the BRAM enable, byte-write strobes, word index and write data, and captures read data one cycle later.
- Returns responses in order through a 4-entry response FIFO, so a slow ack stalls the grant rather than dropping data.
- Sits between the interconnect and the on-chip RAM/ROM instances.

Parameters:
- BASE, 32'h0000_0000: byte address of the first BRAM location; must be DEPTH-aligned.
- DEPTH, 1024: BRAM size in bytes, power of two, at least 8.
- LW, $clog2(DEPTH): local, BRAM address width.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  reset, asynchronous, active-low.
- mem_req  in  1  request valid.
- mem_gnt  out  1  request accepted when mem_req && mem_gnt.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  4  byte write strobes.
- mem_wdata  in  32  write data.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_recv  out  1  response valid.
- mem_ack  in  1  response consumed when mem_recv && mem_ack.
- mem_error  out  1  response is an error.
- mem_rdata  out  32  response read data.
- bram_en  out  1  BRAM port enable.
- bram_wen  out  4  BRAM byte write enables.
- bram_addr  out  LW  BRAM byte address, with bits [1:0] = 0.
- bram_wdata  out  32  BRAM write data.
- bram_rdata  in  32  BRAM registered read data, valid the cycle after bram_en.

Behaviour:
- Reset (async, g_resetn=0):
  - FIFO count, read and write pointers = 0; inflight = 0.
  - mem_recv = 0, mem_error = 0, mem_rdata = 0.
  - mem_gnt = 1 once g_resetn is released.
- Range check: in_range = ((mem_addr - BASE) < DEPTH), computed in 32-bit unsigned arithmetic, so addresses below BASE wrap high and fail.
- Grant: mem_gnt = (count + inflight) < 4. This is combinational from registers only and never depends on mem_req or mem_ack.
- Accept: accept = mem_req && mem_gnt.
- BRAM drive (combinational):
  - bram_en = accept && in_range.
  - bram_wen = (mem_wen ? mem_strb : 4'b0), qualified by bram_en.
  - bram_addr = {(mem_addr - BASE)[LW-1:2], 2'b00}.
  - bram_wdata = mem_wdata.
- Inflight stage (registers):
  - On accept: inflight <= 1; if_err <= !in_range; if_wr <= mem_wen.
  - Otherwise: inflight <= 0.
- Push (cycle after accept, when inflight = 1):
  - Enqueue {err = if_err, data}.
  - data = bram_rdata for an in-range read; 32'h0 for writes and errors.
  - The BRAM's read-during-write data is masked.
- Pop: on mem_recv && mem_ack.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Push with FIFO full is impossible by the grant rule; an assertion checks it.
- Response outputs:
  - mem_recv = (count != 0).
  - mem_rdata and mem_error come from the head entry.
  - They stay stable while mem_recv && !mem_ack.
- Timing:
  - Latency: accept at the cycle-N edge gives mem_recv at earliest in cycle N+2.
  - Throughput: one request per cycle is sustained while mem_ack is held at 1, with steady state inflight = 1 and count = 1.
- Ordering: responses are strictly in accept order; error responses occupy the same pipeline slot.
- Errors: an out-of-range request never asserts bram_en and never corrupts memory.
- Reset mid-operation: in-flight and queued responses are discarded with no response. The BRAM contents are not touched by the bridge.

Decomposition:
- Shared package scarv_soc_mem_pkg holds:
  - response-entry width (33 bits: err + data);
  - FIFO depth constant RSP_DEPTH = 4;
  - the error-data constant 32'h0.
- Sub-module scarv_soc_rsp_fifo is natural: a 4-entry, 33-bit synchronous FIFO with async active-low reset and count output. It is reused by the other bus bridges.

Test Plan:
1. Single write then read:
   - Stimulus: write addr BASE+0x10, strb 4'hF, data 32'hDEADBEEF; then read BASE+0x10.
   - Response: write returns error 0, rdata 0; read returns 32'hDEADBEEF, error 0; mem_recv first high in cycle N+2.
2. Byte strobe:
   - Stimulus: write 32'h11223344 with strb 4'b0100 over prior 32'hDEADBEEF; read back.
   - Response: 32'hDE22BEEF.
3. Out of range:
   - Stimulus: read at BASE+DEPTH, then read at BASE-4.
   - Response: bram_en stays 0 for both; both responses have error 1, rdata 0; a following in-range read still returns correct data in order.
4. Backpressure:
   - Stimulus: mem_ack held 0; issue 6 back-to-back reads.
   - Response: exactly 4 grants and mem_gnt = 0 thereafter; head data stays stable; releasing ack drains 4 responses in order, then grants resume.
5. Full throughput:
   - Stimulus: mem_ack = 1; 16 consecutive reads of words 0..15 preloaded with their index.
   - Response: 16 accepts in 16 cycles; responses 0..15 arrive on consecutive cycles.
6. Reset mid-stream:
   - Stimulus: pulse g_resetn low with 2 responses queued and 1 inflight.
   - Response: mem_recv = 0 immediately; no stale responses after release; mem_gnt = 1 in the first cycle after release.

Source files
------------

// File: rtl/scarv_soc_mem_pkg.sv
// Shared definitions for the SoC memory bus bridges: response entry layout
// and response FIFO sizing.
package scarv_soc_mem_pkg;

  localparam int RSP_DEPTH = 4;
  localparam int RSP_PTR_W = $clog2(RSP_DEPTH);
  localparam int RSP_CNT_W = RSP_PTR_W + 1;

  localparam logic [31:0] ERR_DATA = 32'h0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/scarv_soc_rsp_fifo.sv
// Small in-order response FIFO shared by the bus bridges; head is valid
// whenever count is non-zero.
module scarv_soc_rsp_fifo
  import scarv_soc_mem_pkg::*;
(
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 push,
  input  rsp_t                 push_data,
  input  logic                 pop,
  output rsp_t                 head,
  output logic [RSP_CNT_W-1:0] count
);

  rsp_t                 mem [RSP_DEPTH];
  logic [RSP_PTR_W-1:0] wr_ptr;
  logic [RSP_PTR_W-1:0] rd_ptr;
  logic                 do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // The grant logic upstream keeps a push from ever landing on a full FIFO.
      assert (!(push && count == RSP_CNT_W'(RSP_DEPTH)));
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/scarv_soc_bram_bridge.sv
// Bus initiator onto one BRAM port: window decode, one-cycle read capture
// and an in-order response FIFO that throttles the grant.
module scarv_soc_bram_bridge
  import scarv_soc_mem_pkg::*;
#(
  parameter  logic [31:0] BASE  = 32'h0000_0000,
  parameter  int unsigned DEPTH = 1024,
  localparam int          LW    = $clog2(DEPTH)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          mem_req,
  output logic          mem_gnt,
  input  logic          mem_wen,
  input  logic [3:0]    mem_strb,
  input  logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_addr,
  output logic          mem_recv,
  input  logic          mem_ack,
  output logic          mem_error,
  output logic [31:0]   mem_rdata,
  output logic          bram_en,
  output logic [3:0]    bram_wen,
  output logic [LW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   bram_rdata
);

  localparam int OCC_W = RSP_CNT_W + 1;

  logic [31:0]          offset_p0;
  logic                 in_range_p0;
  logic                 accept_p0;
  logic [OCC_W-1:0]     occupancy;
  logic [RSP_CNT_W-1:0] count;
  rsp_t                 head;
  rsp_t                 push_data;
  logic                 pop;

  logic                 vld_p1;
  logic                 err_p1;
  logic                 wr_p1;

  // Stage 0: decode and drive the BRAM port combinationally.
  // Unsigned subtraction makes addresses below BASE wrap high and miss.
  assign offset_p0   = mem_addr - BASE;
  assign in_range_p0 = offset_p0 < 32'(DEPTH);

  // Every accepted request reserves a FIFO slot, including the one in flight.
  assign occupancy = {1'b0, count} + {{RSP_CNT_W{1'b0}}, vld_p1};
  assign mem_gnt   = occupancy < OCC_W'(RSP_DEPTH);
  assign accept_p0 = mem_req && mem_gnt;

  assign bram_en    = accept_p0 && in_range_p0;
  assign bram_wen   = (bram_en && mem_wen) ? mem_strb : 4'b0000;
  assign bram_addr  = {offset_p0[LW-1:2], 2'b00};
  assign bram_wdata = mem_wdata;

  // Stage 1: one-cycle wait for the registered BRAM read data.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) vld_p1 <= 1'b0;
    else           vld_p1 <= accept_p0;
  end

  always_ff @(posedge g_clk) begin
    if (accept_p0) begin
      err_p1 <= !in_range_p0;
      wr_p1  <= mem_wen;
    end
  end

  // Write and error responses carry zero data; read-during-write data is dropped.
  assign push_data.err  = err_p1;
  assign push_data.data = (err_p1 || wr_p1) ? ERR_DATA : bram_rdata;

  // Stage 2: queued responses, in accept order.
  assign pop = mem_recv && mem_ack;

  scarv_soc_rsp_fifo u_rsp_fifo (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .push      (vld_p1),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign mem_recv  = (count != '0);
  assign mem_error = mem_recv ? head.err  : 1'b0;
  assign mem_rdata = mem_recv ? head.data : 32'h0;

endmodule
